reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- General-purpose register file for the single-cycle CPU datapath.
- Consumes the write-back value produced by the pipeline/state registers and feeds operands to the ALU stage.
- Internally an array of enable-gated, async-reset registers.
- Two combinational read ports, one synchronous write port, register 0 hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of read/write data.
- ADDR_W, 5, address width; the file holds 2**ADDR_W entries.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset; clears every register
- we3  input  1  write enable for port 3
- a1  input  ADDR_W  read address, port 1
- a2  input  ADDR_W  read address, port 2
- a3  input  ADDR_W  write address, port 3
- wd3  input  DATA_W  write data, port 3
- rd1  output  DATA_W  read data, port 1
- rd2  output  DATA_W  read data, port 2

Interface:
- One clock, clk. Reset is rst: asynchronous, active-high.

Behaviour:
- Reset:
  - rst rising asserts immediately, independent of clk, and sets all 2**ADDR_W entries to 0.
  - While rst=1, writes are ignored, and rd1/rd2 read 0.
  - Deassertion takes effect at the next rising clk edge; the first write can occur on that edge.
- Storage:
  - Entry k updates on a rising clk edge only when rst=0, we3=1, a3==k and k!=0.
  - Otherwise every entry holds its value.
- Register 0:
  - Never written. A write to a3=0 is silently dropped.
  - rd1 is 0 whenever a1=0; rd2 is 0 whenever a2=0, in all cases.
- Read latency:
  - Zero cycles. rd1/rd2 are combinational functions of a1/a2 and current storage.
  - No read enable, no read-side state.
- Write latency:
  - Data presented on wd3 with we3=1 is visible on a read port in the cycle after the capturing edge.
- Simultaneous read/write to same address (no bypass):
  - The read returns the old contents during the write cycle and the new contents after the edge.
- Both read ports may address the same entry, and either may match a3; each port is resolved independently.
- X handling: address or data X with we3=0 must not corrupt storage.
- Widths: no arithmetic; a3 outside range cannot occur because the depth is 2**ADDR_W exactly.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- When defined, write-to-read forwarding is enabled:
  - if we3=1, rst=0, a3!=0 and a1==a3, then rd1=wd3 combinationally in the same cycle;
  - rd2 is forwarded the same way when a2==a3.
  - Storage update timing is unchanged.
  - a3=0 is never forwarded.
- When not defined: no forwarding path; same-address reads return the stored (old) value as described above.

Test Plan:
- Reset: write 32'hDEADBEEF to r5, assert rst mid-cycle (between edges) -> rd1 with a1=5 reads 0 immediately, before the next edge; remains 0 after rst deasserts.
- Basic write/read: we3=1, a3=7, wd3=32'h12345678 at edge; next cycle a1=7, a2=7 -> rd1=rd2=32'h12345678. Then we3=0 with wd3=32'hFFFFFFFF for 3 cycles -> value unchanged.
- Register 0: we3=1, a3=0, wd3=32'hAAAA5555 -> rd1 (a1=0) reads 0 before and after the edge.
- Same-cycle hazard: r3 holds 32'h1; write 32'h2 to r3 while a1=3:
  - without REG_FILE_BYPASS_EN -> rd1=32'h1 in that cycle, 32'h2 after;
  - with the macro -> rd1=32'h2 in that cycle.
- Dual port independence: r1=32'h11, r31=32'h1F; a1=1, a2=31 -> rd1=32'h11, rd2=32'h1F. Swap the addresses -> outputs swap in the same cycle.
- Full sweep: write k*32'h01010101 to every k=1..31 on consecutive edges, then read all pairs -> every entry matches, r0 reads 0.

Source files
------------

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file: general-purpose register file for the single-cycle CPU datapath.
//
// Holds 2**ADDR_W entries of DATA_W bits. Two combinational read ports feed
// the ALU operands. One synchronous write port takes the write-back value.
// Entry 0 is hardwired to zero: writes to it are dropped, and reads of it
// return 0.
//
// Optional feature (macro REG_FILE_BYPASS_EN):
//   When defined, a write in flight is forwarded combinationally to any read
//   port whose address matches a3. Storage update timing does not change.
//   Address 0 is never forwarded, and nothing is forwarded while rst is high.
//   When undefined, a same-cycle read of the written address returns the
//   old stored value.
//
// Parameters:
//   DATA_W - register / data width
//   ADDR_W - address width; depth is exactly 2**ADDR_W
//
// Ports:
//   clk  - system clock; storage updates on the rising edge
//   rst  - asynchronous active-high reset; clears every entry
//   we3  - write enable, port 3
//   a1   - read address, port 1
//   a2   - read address, port 2
//   a3   - write address, port 3
//   wd3  - write data, port 3
//   rd1  - read data, port 1 (combinational)
//   rd2  - read data, port 2 (combinational)
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we3,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [Depth-1:0]  wen;

    // One-hot write decode. Entry 0 is never selected, so a write to it
    // disappears here. The enable is gated on we3 first, so X on a3 or wd3
    // with we3=0 cannot select an entry.
    always_comb begin
        wen = '0;
        if (we3 && (a3 != '0)) begin
            wen[a3] = 1'b1;
        end
    end

    // Enable-gated storage with asynchronous clear. Entry 0 is cleared on
    // reset. It is never enabled afterwards, but the read mux also forces 0
    // for address 0, so it reads 0 even before the first reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < Depth; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k < Depth; k++) begin
                if (wen[k]) begin
                    mem_q[k] <= wd3;
                end
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic fwd_valid;
    logic fwd1;
    logic fwd2;

    // a3 != 0 keeps the zero register out of the forwarding path.
    assign fwd_valid = we3 && !rst && (a3 != '0);
    assign fwd1      = fwd_valid && (a1 == a3);
    assign fwd2      = fwd_valid && (a2 == a3);

    always_comb begin
        rd1 = '0;
        if (a1 == '0) begin
            rd1 = '0;
        end else if (fwd1) begin
            rd1 = wd3;
        end else begin
            rd1 = mem_q[a1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (a2 == '0) begin
            rd2 = '0;
        end else if (fwd2) begin
            rd2 = wd3;
        end else begin
            rd2 = mem_q[a2];
        end
    end
`else
    // No bypass: each port reads storage only, so a same-cycle write to the
    // addressed entry shows up after the capturing edge.
    always_comb begin
        rd1 = '0;
        if (a1 != '0) begin
            rd1 = mem_q[a1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (a2 != '0) begin
            rd2 = mem_q[a2];
        end
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk;
    logic          rst;
    logic          we3;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;

    int checks = 0;
    int errors = 0;

    reg_file #(
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .we3(we3),
        .a1 (a1),
        .a2 (a2),
        .a3 (a3),
        .wd3(wd3),
        .rd1(rd1),
        .rd2(rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the stimulus is fixed-length, so this should never fire.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    typedef struct {
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        string         name;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle just after a rising edge and push the expected reads
    // to the scoreboard. Pop and compare at the falling edge, then move on
    // to the next rising edge.
    task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                         input string name);
        exp_t e;
        we3 = we;
        a3  = wa;
        wd3 = wd;
        a1  = ra1;
        a2  = ra2;
        sb.push_back('{e1: e1, e2: e2, name: name});
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got empty scoreboard expected entry", name);
        end else begin
            e = sb.pop_front();
            check({e.name, ".rd1"}, rd1, e.e1);
            check({e.name, ".rd2"}, rd2, e.e2);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[11];
    logic [DW-1:0] hz_exp;
    logic [DW-1:0] pat;

    initial begin
        // Each expected value is what the reads return in that row's cycle,
        // before that row's write edge.
        vecs[0]  = '{1'b1, 5'd7,  32'h12345678, 5'd0,  5'd1,  32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd7,  32'hFFFFFFFF, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
        vecs[2]  = '{1'b0, 5'd7,  32'hFFFFFFFF, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
        vecs[3]  = '{1'b0, 5'd7,  32'hFFFFFFFF, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
        vecs[4]  = '{1'b1, 5'd0,  32'hAAAA5555, 5'd0,  5'd7,  32'h0,        32'h12345678};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[6]  = '{1'b1, 5'd1,  32'h11,       5'd2,  5'd31, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, 5'd31, 32'h1F,       5'd1,  5'd7,  32'h11,       32'h12345678};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h11,       32'h1F};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd1,  32'h1F,       32'h11};
        vecs[10] = '{1'b1, 5'd3,  32'h1,        5'd7,  5'd31, 32'h12345678, 32'h1F};

        rst = 1'b1;
        we3 = 1'b0;
        a1  = '0;
        a2  = '0;
        a3  = '0;
        wd3 = '0;

        @(posedge clk);
        @(posedge clk);
        #1;
        a1 = 5'd5;
        a2 = 5'd31;
        #1;
        check("reset.rd1", rd1, 32'h0);
        check("reset.rd2", rd2, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2,
                  vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));
        end

        // Same-cycle hazard: r3 holds 1 and is rewritten with 2 while both
        // ports read it.
`ifdef REG_FILE_BYPASS_EN
        hz_exp = 32'h2;
`else
        hz_exp = 32'h1;
`endif
        cycle(1'b1, 5'd3, 32'h2, 5'd3, 5'd3, hz_exp, hz_exp, "hazard.same");
        cycle(1'b0, 5'd3, 32'h0, 5'd3, 5'd0, 32'h2, 32'h0, "hazard.after");

        // Asynchronous reset between edges.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 32'h0, 32'h0, "rst.wr");
        we3 = 1'b0;
        a1  = 5'd5;
        a2  = 5'd7;
        #1;
        check("rst.pre", rd1, 32'hDEADBEEF);
        #1;
        rst = 1'b1;
        #1;
        check("rst.imm.rd1", rd1, 32'h0);
        check("rst.imm.rd2", rd2, 32'h0);
        we3 = 1'b1;
        a3  = 5'd5;
        wd3 = 32'hCAFEF00D;
        a2  = 5'd5;
        #1;
        check("rst.nofwd.rd1", rd1, 32'h0);
        @(posedge clk);
        #1;
        check("rst.wr_ignored", rd1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        we3 = 1'b0;
        #1;
        check("rst.deassert", rd1, 32'h0);
        @(posedge clk);
        #1;
        a2 = 5'd7;
        #1;
        check("rst.after.rd1", rd1, 32'h0);
        check("rst.after.rd2", rd2, 32'h0);

        // Full sweep: write every entry on consecutive edges, then read pairs.
        for (int k = 1; k < 32; k++) begin
            pat = 32'h01010101 * k;
            cycle(1'b1, k[AW-1:0], pat, 5'd0, 5'd0, 32'h0, 32'h0, $sformatf("sweep.wr%0d", k));
        end
        for (int k = 0; k < 32; k++) begin
            cycle(1'b0, 5'd0, 32'h0, k[AW-1:0], 5'(31 - k),
                  32'h01010101 * k, 32'h01010101 * (31 - k), $sformatf("sweep.rd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
